wb_arbiter_2to1: RTL and testbench

Two-master to one-slave Wishbone B4 (classic, non-pipelined) arbiter placed directly downstream of the core. It merges the core's instruction-fetch and data-access master buses onto a single memory/peripheral bus. Each transaction is granted atomically for the full `cyc` period. A bus watchdog terminates stalled cycles with an error.

---
 rtl/wb_arbiter_2to1_pkg.sv | 22 ++
 rtl/wb_watchdog.sv | 35 +++
 rtl/wb_arbiter_2to1.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter_2to1.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arbiter_2to1_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } arb_owner_t;

   localparam int WB_ARB_TIMEOUT_DEFAULT = 255;

   // Grant state that corresponds to a given owner.
   function automatic arb_state_t grant_of(input arb_owner_t owner);
      return (owner == OWNER_D) ? GNT_D : GNT_I;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles a granted strobe waits for termination and
// pulses fire for one cycle when the wait reaches TIMEOUT_CYCLES.
module wb_watchdog
   import wb_arbiter_2to1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic done,
   output logic fire
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] count;
   logic        waiting;

   // A termination in the same cycle suppresses the fire (ack wins).
   assign waiting = active && !done;
   assign fire    = waiting && (count == LIMIT);

   // Wait counter: runs while stalled, clears on termination, idle or fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (waiting && !fire) begin
         count <= count + 16'd1;
      end else begin
         count <= '0;
      end
   end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone B4 classic arbiter with bus watchdog.
// Optional build macro: WB_ARB_ROUND_ROBIN_EN (round-robin on ties);
// without it the data master always wins a tie.
//
// state | meaning
// IDLE  | no owner, all shared outputs 0
// GNT_I | fetch master owns the bus until i_cyc drops
// GNT_D | data master owns the bus until d_cyc drops
module wb_arbiter_2to1
   import wb_arbiter_2to1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cyc,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_dat_w,
   input  logic [3:0]  i_sel,
   output logic [31:0] i_dat_r,
   output logic        i_ack,
   output logic        i_err,
   input  logic        d_cyc,
   input  logic        d_stb,
   input  logic        d_we,
   input  logic [31:0] d_adr,
   input  logic [31:0] d_dat_w,
   input  logic [3:0]  d_sel,
   output logic [31:0] d_dat_r,
   output logic        d_ack,
   output logic        d_err,
   output logic        m_cyc,
   output logic        m_stb,
   output logic        m_we,
   output logic [31:0] m_adr,
   output logic [31:0] m_dat_w,
   output logic [3:0]  m_sel,
   input  logic [31:0] m_dat_r,
   input  logic        m_ack,
   input  logic        m_err
);

   arb_state_t state;
   arb_state_t state_nxt;
   arb_state_t tie_grant;
   logic       wd_active;
   logic       wd_fire;

`ifdef WB_ARB_ROUND_ROBIN_EN
   arb_owner_t last_owner;

   assign tie_grant = (last_owner == OWNER_I) ? grant_of(OWNER_D) : grant_of(OWNER_I);

   // Remember who was granted last; reset state makes data win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner <= OWNER_I;
      end else if (state == IDLE && state_nxt == GNT_I) begin
         last_owner <= OWNER_I;
      end else if (state == IDLE && state_nxt == GNT_D) begin
         last_owner <= OWNER_D;
      end
   end
`else
   assign tie_grant = grant_of(OWNER_D);
`endif

   // Watchdog watches the owner's raw strobe so the forced-low m_stb cannot feed back.
   assign wd_active = ((state == GNT_I) && i_stb) || ((state == GNT_D) && d_stb);

   wb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (wd_active),
      .done   (m_ack || m_err),
      .fire   (wd_fire)
   );

   // Next-state: grant from IDLE only, hold the grant for the whole cyc.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_cyc && d_cyc) begin
               state_nxt = tie_grant;
            end else if (d_cyc) begin
               state_nxt = GNT_D;
            end else if (i_cyc) begin
               state_nxt = GNT_I;
            end
         end
         GNT_I:   if (!i_cyc) state_nxt = IDLE;
         GNT_D:   if (!d_cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Output mux: owner drives the shared bus and alone sees the responses.
   always_comb begin
      m_cyc   = 1'b0;
      m_stb   = 1'b0;
      m_we    = 1'b0;
      m_adr   = '0;
      m_dat_w = '0;
      m_sel   = '0;
      i_dat_r = '0;
      i_ack   = 1'b0;
      i_err   = 1'b0;
      d_dat_r = '0;
      d_ack   = 1'b0;
      d_err   = 1'b0;
      case (state)
         GNT_I: begin
            m_cyc   = i_cyc;
            m_stb   = i_stb && !wd_fire;
            m_we    = i_we;
            m_adr   = i_adr;
            m_dat_w = i_dat_w;
            m_sel   = i_sel;
            i_dat_r = m_dat_r;
            i_ack   = m_ack;
            i_err   = m_err || wd_fire;
         end
         GNT_D: begin
            m_cyc   = d_cyc;
            m_stb   = d_stb && !wd_fire;
            m_we    = d_we;
            m_adr   = d_adr;
            m_dat_w = d_dat_w;
            m_sel   = d_sel;
            d_dat_r = m_dat_r;
            d_ack   = m_ack;
            d_err   = m_err || wd_fire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: directed scenarios followed by
// random traffic, all cycles checked against a transaction-level model.
module tb_wb_arbiter_2to1;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cyc, i_stb, i_we;
   logic [31:0] i_adr, i_dat_w, i_dat_r;
   logic [3:0]  i_sel;
   logic        i_ack, i_err;
   logic        d_cyc, d_stb, d_we;
   logic [31:0] d_adr, d_dat_w, d_dat_r;
   logic [3:0]  d_sel;
   logic        d_ack, d_err;
   logic        m_cyc, m_stb, m_we;
   logic [31:0] m_adr, m_dat_w, m_dat_r;
   logic [3:0]  m_sel;
   logic        m_ack, m_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   wb_arbiter_2to1 #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
      .i_sel(i_sel), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
      .d_sel(d_sel), .d_dat_r(d_dat_r), .d_ack(d_ack), .d_err(d_err),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
      .m_sel(m_sel), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the bus (0 none, 1 fetch, 2 data), how long
   // the owner's strobe has waited, and who won last (1 fetch, 2 data).
   int owner     = 0;
   int wait_cnt  = 0;
   int last_won  = 1;
   logic        o_stb, stalled, fire;
   logic [6:0]  e_ctl;
   logic [31:0] e_adr, e_datw, e_idat, e_ddat;
   logic [1:0]  e_iresp, e_dresp;

   always @(negedge clk) begin
      if (mon_en) begin
         o_stb   = (owner == 1) ? i_stb : (owner == 2) ? d_stb : 1'b0;
         stalled = o_stb && !m_ack && !m_err;
         fire    = stalled && (wait_cnt == T);
         e_ctl = '0; e_adr = '0; e_datw = '0; e_idat = '0; e_ddat = '0;
         e_iresp = '0; e_dresp = '0;
         if (owner == 1) begin
            e_ctl   = {i_cyc, i_stb && !fire, i_we, i_sel};
            e_adr   = i_adr;
            e_datw  = i_dat_w;
            e_idat  = m_dat_r;
            e_iresp = {m_ack, m_err || fire};
         end else if (owner == 2) begin
            e_ctl   = {d_cyc, d_stb && !fire, d_we, d_sel};
            e_adr   = d_adr;
            e_datw  = d_dat_w;
            e_ddat  = m_dat_r;
            e_dresp = {m_ack, m_err || fire};
         end
         chk("mdl_m_ctl",  32'({m_cyc, m_stb, m_we, m_sel}), 32'(e_ctl));
         chk("mdl_m_adr",  m_adr, e_adr);
         chk("mdl_m_datw", m_dat_w, e_datw);
         chk("mdl_i_resp", 32'({i_ack, i_err}), 32'(e_iresp));
         chk("mdl_i_datr", i_dat_r, e_idat);
         chk("mdl_d_resp", 32'({d_ack, d_err}), 32'(e_dresp));
         chk("mdl_d_datr", d_dat_r, e_ddat);
         // Advance to what the next rising edge produces.
         if (rst) begin
            owner = 0; wait_cnt = 0; last_won = 1;
         end else begin
            wait_cnt = (stalled && !fire) ? wait_cnt + 1 : 0;
            if (owner == 0) begin
               if (i_cyc && d_cyc) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                  owner = (last_won == 1) ? 2 : 1;
`else
                  owner = 2;
`endif
               end else if (d_cyc) owner = 2;
               else if (i_cyc)     owner = 1;
               if (owner != 0) last_won = owner;
            end else if ((owner == 1 && !i_cyc) || (owner == 2 && !d_cyc)) begin
               owner = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clr_in();
      i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
      d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_w = '0; d_sel = '0;
      m_dat_r = '0; m_ack = 0; m_err = 0;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      tick();
      mon_en = 1'b1;
      tick();
      settle();
      chk("rst_m_cyc", 32'(m_cyc), 32'd0);
      chk("rst_acks",  32'({i_ack, i_err, d_ack, d_err}), 32'd0);
      tick();
      rst = 1'b0;
      settle();

      // Fetch-only read, acked on the second strobe cycle.
      tick(); i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0100; i_sel = 4'hF; settle();
      chk("rd_idle_m_cyc", 32'(m_cyc), 32'd0);
      tick(); settle();
      chk("rd_m_adr", m_adr, 32'h0000_0100);
      chk("rd_m_stb", 32'(m_stb), 32'd1);
      chk("rd_i_ack_wait", 32'(i_ack), 32'd0);
      tick(); m_ack = 1; m_dat_r = 32'h0000_0013; settle();
      chk("rd_i_ack", 32'(i_ack), 32'd1);
      chk("rd_i_dat_r", i_dat_r, 32'h0000_0013);
      chk("rd_d_ack", 32'(d_ack), 32'd0);
      tick(); clr_in(); settle();
      chk("rd_ack_once", 32'(i_ack), 32'd0);
      tick(); settle();

      // Tie straight out of reset, then a second tie.
      tick(); rst = 1; settle();
      tick(); rst = 0;
      i_cyc = 1; i_stb = 1; i_adr = 32'h100;
      d_cyc = 1; d_stb = 1; d_adr = 32'h200;
      settle();
      chk("tie_idle", 32'(m_cyc), 32'd0);
      tick(); m_ack = 1; settle();
      chk("tie_first", m_adr, 32'h200);
      chk("tie_d_ack", 32'(d_ack), 32'd1);
      chk("tie_i_ack", 32'(i_ack), 32'd0);
      tick(); m_ack = 0; d_cyc = 0; d_stb = 0; settle();
      chk("tie_drop", 32'(m_cyc), 32'd0);
      tick(); d_cyc = 1; d_stb = 1; settle();
      chk("tie_gap", 32'(m_cyc), 32'd0);
      tick(); settle();
`ifdef WB_ARB_ROUND_ROBIN_EN
      chk("tie_second", m_adr, 32'h100);
`else
      chk("tie_second", m_adr, 32'h200);
`endif
      tick(); clr_in(); settle();
      tick(); settle();

      // Data write while fetch waits.
      tick(); d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'b0011;
      d_dat_w = 32'hCAFE_0042; d_adr = 32'h300; settle();
      tick(); i_cyc = 1; i_stb = 1; i_adr = 32'h100; settle();
      chk("wr_m_sel", 32'(m_sel), 32'h3);
      chk("wr_m_we", 32'(m_we), 32'd1);
      chk("wr_m_dat_w", m_dat_w, 32'hCAFE_0042);
      tick(); settle();
      chk("wr_hold", m_adr, 32'h300);
      tick(); m_ack = 1; settle();
      chk("wr_d_ack", 32'(d_ack), 32'd1);
      tick(); m_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0; settle();
      chk("wr_no_i_grant", 32'(m_cyc), 32'd0);
      tick(); settle();
      chk("wr_gap", 32'(m_cyc), 32'd0);
      tick(); settle();
      chk("wr_i_grant", m_adr, 32'h100);
      chk("wr_i_cyc", 32'(m_cyc), 32'd1);
      tick(); m_ack = 1; settle();
      tick(); clr_in(); settle();
      tick(); settle();

      // Watchdog on a slave that never answers.
      tick(); d_cyc = 1; d_stb = 1; d_adr = 32'h400; settle();
      for (int k = 1; k <= 6; k++) begin
         tick(); settle();
         chk("wd_d_err", 32'(d_err), 32'(k == 5));
         chk("wd_m_stb", 32'(m_stb), 32'(k != 5));
         chk("wd_d_ack", 32'(d_ack), 32'd0);
      end
      tick(); clr_in(); settle();
      tick(); settle();

      // Ack on the cycle the watchdog would fire.
      tick(); d_cyc = 1; d_stb = 1; d_adr = 32'h500; settle();
      for (int k = 1; k <= 5; k++) begin
         tick(); m_ack = (k == 5); settle();
         chk("race_d_ack", 32'(d_ack), 32'(k == 5));
         chk("race_d_err", 32'(d_err), 32'd0);
      end
      tick(); clr_in(); settle();
      tick(); settle();

      // Reset in the middle of a fetch wait.
      tick(); i_cyc = 1; i_stb = 1; i_adr = 32'h600; settle();
      tick(); settle();
      tick(); settle();
      tick(); rst = 1; settle();
      tick(); rst = 0; m_ack = 1; m_err = 1; settle();
      chk("mid_rst_m_cyc", 32'(m_cyc), 32'd0);
      chk("mid_rst_i_resp", 32'({i_ack, i_err}), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         tick(); m_ack = 0; m_err = 0; settle();
         chk("mid_rst_wd", 32'(i_err), 32'(k == 5));
      end
      tick(); clr_in(); settle();
      tick(); settle();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (i_cyc) begin
            if ($urandom_range(9) == 0) i_cyc = 0;
         end else if ($urandom_range(3) == 0) i_cyc = 1;
         if (d_cyc) begin
            if ($urandom_range(9) == 0) d_cyc = 0;
         end else if ($urandom_range(3) == 0) d_cyc = 1;
         i_stb   = i_cyc && ($urandom_range(4) != 0);
         d_stb   = d_cyc && ($urandom_range(4) != 0);
         i_we    = 1'($urandom);
         d_we    = 1'($urandom);
         i_adr   = $urandom;
         d_adr   = $urandom;
         i_dat_w = $urandom;
         d_dat_w = $urandom;
         i_sel   = 4'($urandom);
         d_sel   = 4'($urandom);
         m_dat_r = $urandom;
         m_ack   = ($urandom_range(5) == 0);
         m_err   = ($urandom_range(29) == 0);
         rst     = ($urandom_range(199) == 0);
         settle();
      end

      tick(); rst = 0; clr_in(); settle();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
